pipe_scan_reader: RTL and testbench

//  Reader end of the pipe-position stream driven by the X-position RAM/counter
//  (x value plus pipe index per strobe). Captures the stream into a 4-entry live table.

---
 rtl/pipe_scan_reader_pkg.sv | 12 +
 rtl/pipe_scan_reader_slot_cmp.sv | 22 ++
 rtl/pipe_scan_reader.sv | 92 +++++++++
 tb/tb_pipe_scan_reader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_scan_reader_pkg.sv
// pipe_scan_reader_pkg: shared constants, FSM encodings and gap helper
package pipe_scan_reader_pkg;
   localparam int PIPE_COUNT = 4;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] HIT = 2'd2;
   function automatic logic [9:0] gap_top_of(input int idx, input int base, input int step);
      return 10'(base + idx * step);
   endfunction
endpackage

// File: rtl/pipe_scan_reader_slot_cmp.sv
// pipe_slot_cmp: pipe-body hit test for one display slot at the current pixel
module pipe_slot_cmp #(
   parameter int PIPE_W = 40,
   parameter int GAP_H = 120
) (
   input  logic [9:0] x,
   input  logic       valid,
   input  logic [9:0] gap_top,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   output logic       term
);
   logic [10:0] h, v, xl, gt;
   logic in_x, in_gap;
   assign h = {1'b0, hcount};
   assign v = {1'b0, vcount};
   assign xl = {1'b0, x};
   assign gt = {1'b0, gap_top};
   assign in_x = h >= xl && h <= xl + 11'(PIPE_W - 1);
   assign in_gap = v >= gt && v <= gt + 11'(GAP_H - 1);
   assign term = valid && in_x && !in_gap;
endmodule

// File: rtl/pipe_scan_reader.sv
// pipe_scan_reader: pipe table capture, per-pixel pipe/bird query and collision FSM
module pipe_scan_reader
   import pipe_scan_reader_pkg::*;
#(
   parameter int PIPE_W = 40,
   parameter int GAP_H = 120,
   parameter int GAP_BASE = 80,
   parameter int GAP_STEP = 60,
   parameter int BIRD_X = 160,
   parameter int BIRD_W = 16,
   parameter int BIRD_H = 16,
   parameter int GROUND_Y = 440
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pipe_valid,
   input  logic [9:0] pipe_x,
   input  logic [1:0] pipe_idx,
   input  logic       frame_start,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       active,
   input  logic [9:0] bird_y,
   input  logic       game_run,
   output logic       pipe_pixel,
   output logic       bird_pixel,
   output logic       collide,
   output logic       tbl_ready
);
   logic [9:0] live_x [PIPE_COUNT];
   logic [9:0] disp_x [PIPE_COUNT];
   logic [PIPE_COUNT-1:0] live_v, disp_v, slot_term;
   logic [1:0] state, state_nx;
   logic [10:0] h, v, by;
   logic pipe_term, bird_term, overlap, ground;
   for (genvar i = 0; i < PIPE_COUNT; i++) begin : g_slot
      pipe_slot_cmp #(.PIPE_W(PIPE_W), .GAP_H(GAP_H)) u_slot (
         .x(disp_x[i]),
         .valid(disp_v[i]),
         .gap_top(gap_top_of(i, GAP_BASE, GAP_STEP)),
         .hcount(hcount),
         .vcount(vcount),
         .term(slot_term[i])
      );
   end
   assign h = {1'b0, hcount};
   assign v = {1'b0, vcount};
   assign by = {1'b0, bird_y};
   assign pipe_term = active && |slot_term;
   assign bird_term = active && h >= 11'(BIRD_X) && h <= 11'(BIRD_X + BIRD_W - 1)
                      && v >= by && v <= by + 11'(BIRD_H - 1);
   assign overlap = pipe_term && bird_term;
   assign ground = by + 11'(BIRD_H) > 11'(GROUND_Y);
   assign collide = state == HIT;
   // Next collision state; dropping game_run always wins over a hit
   always_comb
      state_nx = !game_run ? IDLE :
                 state == IDLE ? ARMED :
                 state == ARMED && (overlap || (frame_start && ground)) ? HIT : state;
   // Live bank capture and frame-start snapshot; same-cycle writes miss the snapshot
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int k = 0; k < PIPE_COUNT; k++) begin
            live_x[k] <= '0;
            disp_x[k] <= '0;
         end
         live_v <= '0;
         disp_v <= '0;
      end else begin
         if (pipe_valid) begin
            live_x[pipe_idx] <= pipe_x;
            live_v[pipe_idx] <= 1'b1;
         end
         if (frame_start) begin
            disp_x <= live_x;
            disp_v <= live_v;
         end
      end
   // Registered pixel outputs, collision state and sticky table-ready flag
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pipe_pixel <= 1'b0;
         bird_pixel <= 1'b0;
         state <= IDLE;
         tbl_ready <= 1'b0;
      end else begin
         pipe_pixel <= pipe_term;
         bird_pixel <= bird_term;
         state <= state_nx;
         tbl_ready <= tbl_ready | &live_v;
      end
endmodule

// File: tb/tb_pipe_scan_reader.sv
// tb_pipe_scan_reader: directed vectors with a scoreboard queue and decoupled monitor
module tb_pipe_scan_reader;
   logic clk, reset, pipe_valid, frame_start, active, game_run;
   logic [9:0] pipe_x, hcount, vcount, bird_y;
   logic [1:0] pipe_idx;
   logic pipe_pixel, bird_pixel, collide, tbl_ready;
   logic issue, pend;
   logic [3:0] exp_q [$];
   string name_q [$];
   int checks, failures;

   pipe_scan_reader dut (
      .clk(clk), .reset(reset), .pipe_valid(pipe_valid), .pipe_x(pipe_x),
      .pipe_idx(pipe_idx), .frame_start(frame_start), .hcount(hcount),
      .vcount(vcount), .active(active), .bird_y(bird_y), .game_run(game_run),
      .pipe_pixel(pipe_pixel), .bird_pixel(bird_pixel), .collide(collide),
      .tbl_ready(tbl_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [3:0] got, input logic [3:0] e);
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s: got {pipe,bird,collide,rdy}=%b expected %b", nm, got, e);
      end
   endtask

   // Expected outputs for a vector appear one edge after it is driven
   always @(posedge clk) pend <= issue;
   always @(negedge clk)
      if (pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: got output with no expectation");
         end else
            check(name_q.pop_front(), {pipe_pixel, bird_pixel, collide, tbl_ready}, exp_q.pop_front());
      end

   task automatic step(input logic fs, pv, input logic [9:0] px, input logic [1:0] pi,
                       input logic [9:0] h, v, input logic act, input logic [9:0] by,
                       input logic gr, chk, input logic [3:0] e, input string nm);
      @(negedge clk);
      frame_start = fs; pipe_valid = pv; pipe_x = px; pipe_idx = pi;
      hcount = h; vcount = v; active = act; bird_y = by; game_run = gr; issue = chk;
      if (chk) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
   endtask

   task automatic q(input logic [9:0] h, v, by, input logic gr, input logic [3:0] e, input string nm);
      step(1'b0, 1'b0, 10'd0, 2'd0, h, v, 1'b1, by, gr, 1'b1, e, nm);
   endtask

   task automatic w(input logic [1:0] idx, input logic [9:0] x, input logic fs);
      step(fs, 1'b1, x, idx, 10'd0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 4'b0, "");
   endtask

   task automatic g(input logic fs, input logic [9:0] by, input logic gr, input logic [3:0] e, input string nm);
      step(fs, 1'b0, 10'd0, 2'd0, 10'd0, 10'd0, 1'b0, by, gr, 1'b1, e, nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      checks = 0; failures = 0; issue = 1'b0;
      reset = 1'b0; pipe_valid = 1'b0; pipe_x = '0; pipe_idx = '0; frame_start = 1'b0;
      hcount = '0; vcount = '0; active = 1'b0; bird_y = '0; game_run = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {pipe_pixel, bird_pixel, collide, tbl_ready}, 4'b0000);
      reset = 1'b1;
      q(300, 10, 0, 0, 4'b0000, "pre_snapshot");
      w(0, 300, 0);
      g(1, 0, 0, 4'b0000, "snap0");
      q(300, 10, 0, 0, 4'b1000, "x_left");
      q(339, 10, 0, 0, 4'b1000, "x_right");
      q(340, 10, 0, 0, 4'b0000, "x_past");
      q(299, 10, 0, 0, 4'b0000, "x_before");
      q(310, 100, 0, 0, 4'b0000, "in_gap");
      q(310, 79, 0, 0, 4'b1000, "gap_above");
      q(310, 199, 0, 0, 4'b0000, "gap_last");
      q(310, 200, 0, 0, 4'b1000, "below_gap");
      step(0, 0, 0, 0, 300, 10, 0, 0, 0, 1, 4'b0000, "inactive");
      q(160, 5, 0, 0, 4'b0100, "bird_only");
      q(176, 5, 0, 0, 4'b0000, "bird_right_edge");
      w(1, 500, 1);
      q(500, 10, 0, 0, 4'b0000, "same_cycle_write");
      g(1, 0, 0, 4'b0000, "snap1");
      q(500, 10, 0, 0, 4'b1000, "next_frame");
      q(539, 150, 0, 0, 4'b0000, "idx1_gap");
      w(2, 1000, 0);
      g(1, 0, 0, 4'b0000, "snap2");
      q(1023, 10, 0, 0, 4'b1000, "x_1023");
      q(1000, 250, 0, 0, 4'b0000, "idx2_gap");
      q(999, 10, 0, 0, 4'b0000, "x_999");
      q(10, 10, 0, 0, 4'b0000, "no_wrap");
      step(0, 1, 700, 3, 0, 0, 0, 0, 0, 1, 4'b0000, "rdy_not_yet");
      g(0, 0, 0, 4'b0001, "tbl_ready");
      w(0, 150, 0);
      g(1, 0, 0, 4'b0001, "snap3");
      g(0, 20, 1, 4'b0001, "arm");
      q(150, 20, 20, 1, 4'b1001, "pipe_no_bird");
      q(160, 20, 20, 1, 4'b1111, "hit");
      g(0, 20, 1, 4'b0011, "hit_sticky");
      q(160, 20, 20, 1, 4'b1111, "hit_again");
      g(0, 20, 0, 4'b0001, "hit_clear");
      q(175, 35, 20, 0, 4'b1101, "overlap_idle");
      g(0, 20, 1, 4'b0001, "rearm");
      q(175, 35, 20, 0, 4'b1101, "hit_vs_stop");
      g(0, 20, 0, 4'b0001, "stop_idle");
      g(0, 430, 1, 4'b0001, "arm_ground");
      g(1, 430, 1, 4'b0011, "ground_hit");
      g(0, 430, 0, 4'b0001, "ground_clear");
      g(0, 424, 1, 4'b0001, "arm_424");
      g(1, 424, 1, 4'b0001, "ground_edge");
      g(0, 424, 1, 4'b0001, "ground_edge_hold");
      g(0, 424, 0, 4'b0001, "disarm");
      step(0, 0, 0, 0, 155, 10, 1, 0, 0, 0, 4'b0000, "");
      @(posedge clk);
      #2;
      check("pre_reset", {pipe_pixel, bird_pixel, collide, tbl_ready}, 4'b1001);
      reset = 1'b0;
      #1;
      check("async_reset", {pipe_pixel, bird_pixel, collide, tbl_ready}, 4'b0000);
      @(negedge clk);
      reset = 1'b1;
      q(155, 10, 0, 0, 4'b0000, "after_reset");
      w(0, 150, 0);
      q(155, 10, 0, 0, 4'b0000, "live_only");
      g(1, 0, 0, 4'b0000, "snap4");
      q(155, 10, 0, 0, 4'b1000, "redrawn");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "");
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
